// File: rtl/shift_pipe_if.sv
// shift_pipe_if: handshake bundle for shift_pipe.
// Input channel: in_valid/in_ready/in_data/in_sa/in_op (in_op: 00 SLL, 01 SRL, 10 SRA, 11 ROR).
// Output channel: out_valid/out_ready/out_data, plus out_carry when SHIFT_PIPE_CARRY_EN is defined.
// master drives operations in and consumes results; slave is the shifter.
interface shift_pipe_if #(parameter int WIDTH = 32);
    localparam int LOG2W = $clog2(WIDTH);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [LOG2W-1:0] in_sa;
    logic [1:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
`ifdef SHIFT_PIPE_CARRY_EN
    logic             out_carry;
`endif
    modport master (
        output in_valid, in_data, in_sa, in_op, out_ready,
        input  in_ready, out_valid, out_data
`ifdef SHIFT_PIPE_CARRY_EN
        , input out_carry
`endif
    );
    modport slave (
        input  in_valid, in_data, in_sa, in_op, out_ready,
        output in_ready, out_valid, out_data
`ifdef SHIFT_PIPE_CARRY_EN
        , output out_carry
`endif
    );
endinterface

// File: rtl/shift_pipe.sv
// shift_pipe: pipelined barrel shifter (SLL/SRL/SRA/ROR) with valid/ready handshake.
// Ports: clk, rst (async, active-high), bus (shift_pipe_if.slave): in_valid/in_ready/in_data/
// in_sa/in_op accept operations, out_valid/out_ready/out_data return results after PIPE cycles.
// Optional: define SHIFT_PIPE_CARRY_EN to add out_carry (last bit shifted out, 0 when sa = 0).
module shift_pipe #(
    parameter int WIDTH = 32,
    parameter int PIPE  = 2
) (
    input  logic         clk,
    input  logic         rst,
    shift_pipe_if.slave  bus
);
    localparam int LOG2W = $clog2(WIDTH);
    // Levels per register stage; trailing stages may get none and just pass through.
    localparam int GRP   = (LOG2W + PIPE - 1) / PIPE;

    logic [WIDTH-1:0]   data_q  [PIPE];
    logic [WIDTH-1:0]   data_d  [PIPE];
    logic [LOG2W-1:0]   sa_q    [PIPE];
    logic [LOG2W-1:0]   sa_d    [PIPE];
    logic [1:0]         op_q    [PIPE];
    logic [1:0]         op_d    [PIPE];
    logic               fill_q  [PIPE];
    logic               fill_d  [PIPE];
    logic               valid_q [PIPE];
    logic               valid_d [PIPE];
`ifdef SHIFT_PIPE_CARRY_EN
    logic               carry_q [PIPE];
    logic               carry_d [PIPE];
`endif
    logic [WIDTH-1:0]   ext;
    logic [2*WIDTH-1:0] wide;
    logic               advance;

    // Global stall: every stage freezes while a result waits for the consumer.
    assign advance       = !valid_q[PIPE-1] || bus.out_ready;
    assign bus.in_ready  = advance && !rst;
    assign bus.out_valid = valid_q[PIPE-1];
    assign bus.out_data  = data_q[PIPE-1];
`ifdef SHIFT_PIPE_CARRY_EN
    assign bus.out_carry = carry_q[PIPE-1];
`endif

    always_comb begin
        ext        = '0;
        wide       = '0;
        data_d[0]  = bus.in_data;
        sa_d[0]    = bus.in_sa;
        op_d[0]    = bus.in_op;
        // Sign bit is captured once at entry and only used as fill for SRA.
        fill_d[0]  = bus.in_data[WIDTH-1] && (bus.in_op == 2'b10);
        valid_d[0] = bus.in_valid;
`ifdef SHIFT_PIPE_CARRY_EN
        carry_d[0] = 1'b0;
`endif
        for (int s = 1; s < PIPE; s++) begin
            data_d[s]  = data_q[s-1];
            sa_d[s]    = sa_q[s-1];
            op_d[s]    = op_q[s-1];
            fill_d[s]  = fill_q[s-1];
            valid_d[s] = valid_q[s-1];
`ifdef SHIFT_PIPE_CARRY_EN
            carry_d[s] = carry_q[s-1];
`endif
        end
        for (int s = 0; s < PIPE; s++) begin
            for (int k = LOG2W - 1; k >= 0; k--) begin
                if ((LOG2W - 1 - k) / GRP == s && sa_d[s][k]) begin
                    // The carry of the last non-zero level equals the overall last bit shifted out.
`ifdef SHIFT_PIPE_CARRY_EN
                    carry_d[s] = (op_d[s] == 2'b00) ? data_d[s][WIDTH-(1<<k)] : data_d[s][(1<<k)-1];
`endif
                    ext  = (op_d[s] == 2'b11) ? data_d[s] : {WIDTH{fill_d[s]}};
                    wide = {ext, data_d[s]} >> (1 << k);
                    data_d[s] = (op_d[s] == 2'b00) ? data_d[s] << (1 << k) : wide[WIDTH-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < PIPE; s++) begin
                data_q[s]  <= '0;
                sa_q[s]    <= '0;
                op_q[s]    <= '0;
                fill_q[s]  <= 1'b0;
                valid_q[s] <= 1'b0;
`ifdef SHIFT_PIPE_CARRY_EN
                carry_q[s] <= 1'b0;
`endif
            end
        end else if (advance) begin
            for (int s = 0; s < PIPE; s++) begin
                data_q[s]  <= data_d[s];
                sa_q[s]    <= sa_d[s];
                op_q[s]    <= op_d[s];
                fill_q[s]  <= fill_d[s];
                valid_q[s] <= valid_d[s];
`ifdef SHIFT_PIPE_CARRY_EN
                carry_q[s] <= carry_d[s];
`endif
            end
        end
    end
endmodule

// File: tb/tb_shift_pipe.sv
// tb_shift_pipe: directed and randomized checks of shift_pipe against an arithmetic reference model.
module tb_shift_pipe;
    localparam int WIDTH = 32;
    localparam int PIPE  = 2;
    localparam int LOG2W = $clog2(WIDTH);

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    logic in_x = 1'b0;
    logic [WIDTH:0]   sb [$];
    logic [WIDTH-1:0] hold;

    shift_pipe_if #(.WIDTH(WIDTH)) bus ();
    shift_pipe #(.WIDTH(WIDTH), .PIPE(PIPE)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Returns {carry, result} computed directly from the operation definitions.
    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] d, input int sa, input logic [1:0] op);
        logic [WIDTH-1:0] r;
        logic c;
        case (op)
            2'b00:   r = d << sa;
            2'b01:   r = d >> sa;
            2'b10:   r = WIDTH'($signed(d) >>> sa);
            default: r = (sa == 0) ? d : ((d >> sa) | (d << (WIDTH - sa)));
        endcase
        if (sa == 0)          c = 1'b0;
        else if (op == 2'b00) c = d[WIDTH-sa];
        else if (op == 2'b11) c = r[WIDTH-1];
        else                  c = d[sa-1];
        return {c, r};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record transfers seen before the edge, then advance to the next falling edge.
    task automatic cycle();
        logic [WIDTH:0] e;
        #1;
        in_x = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_data", 64'(bus.out_data), 64'(e[WIDTH-1:0]));
`ifdef SHIFT_PIPE_CARRY_EN
                check("sb_carry", 64'(bus.out_carry), 64'(e[WIDTH]));
`endif
            end
        end
        if (in_x) sb.push_back(model(bus.in_data, int'(bus.in_sa), bus.in_op));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [WIDTH-1:0] d, input int sa, input logic [1:0] op);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sa    = LOG2W'(sa);
        bus.in_op    = op;
        do begin cycle(); n++; end while (!in_x && n < 20);
        check("send_accepted", 64'(in_x), 64'd1);
        bus.in_valid = 1'b0;
    endtask

    task automatic expect_out(input string tag, input logic [WIDTH-1:0] exp);
        int n = 0;
        while (!bus.out_valid && n < 20) begin cycle(); n++; end
        check({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        check(tag, 64'(bus.out_data), 64'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_sa     = '0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'd0);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_data", 64'(bus.out_data), 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        send(32'h8000_0000, 4, 2'b10);
        for (int i = 1; i < PIPE; i++) begin
            check("latency_early", 64'(bus.out_valid), 64'd0);
            cycle();
        end
        check("latency_valid", 64'(bus.out_valid), 64'd1);
        check("sra", 64'(bus.out_data), 64'hF800_0000);
        send(32'h8000_0000, 4, 2'b01);
        expect_out("srl", 32'h0800_0000);
        send(32'h1234_5678, 8, 2'b11);
        expect_out("ror", 32'h7812_3456);
        send(32'h0000_FFFF, 16, 2'b00);
        expect_out("sll", 32'hFFFF_0000);
        for (int op = 0; op < 4; op++) begin
            send(32'hA5A5_F00F, 0, 2'(op));
            expect_out("sa0", 32'hA5A5_F00F);
        end
        send(32'h8000_0001, 31, 2'b10);
        expect_out("sra_max", 32'hFFFF_FFFF);
`ifdef SHIFT_PIPE_CARRY_EN
        send(32'h8000_0001, 1, 2'b00);
        expect_out("sll_c", 32'h0000_0002);
        check("sll_carry", 64'(bus.out_carry), 64'd1);
        send(32'h0000_0002, 2, 2'b01);
        expect_out("srl_c", 32'h0000_0000);
        check("srl_carry", 64'(bus.out_carry), 64'd1);
`endif
        cycle();

        // Back-to-back ops, then backpressure with a pending op held at the input.
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = $urandom;
            bus.in_sa    = LOG2W'($urandom_range(0, WIDTH - 1));
            bus.in_op    = 2'($urandom);
            cycle();
            check("b2b_accept", 64'(in_x), 64'd1);
        end
        bus.in_data   = 32'hCAFE_F00D;
        bus.in_sa     = 5'd3;
        bus.in_op     = 2'b11;
        bus.out_ready = 1'b0;
        #1;
        hold = bus.out_data;
        for (int i = 0; i < 3; i++) begin
            check("stall_in_ready", 64'(bus.in_ready), 64'd0);
            cycle();
            check("stall_data_stable", 64'(bus.out_data), 64'(hold));
        end
        bus.out_ready = 1'b1;
        for (int n = 0; n < 20; n++) begin
            cycle();
            if (in_x) break;
        end
        check("stall_release_accept", 64'(in_x), 64'd1);
        bus.in_valid = 1'b0;
        repeat (PIPE + 3) cycle();
        check("drain_empty", 64'(sb.size()), 64'd0);

        // Reset with two ops in flight: nothing may emerge afterwards.
        bus.in_valid = 1'b1;
        bus.in_data  = 32'h1111_2222;
        bus.in_sa    = 5'd5;
        bus.in_op    = 2'b01;
        repeat (2) cycle();
        bus.in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(bus.out_valid), 64'd0);
        check("midrst_in_ready", 64'(bus.in_ready), 64'd0);
        sb.delete();
        cycle();
        rst = 1'b0;
        for (int i = 0; i < PIPE + 2; i++) begin
            cycle();
            check("no_stale", 64'(bus.out_valid), 64'd0);
        end
        send(32'h0F0F_0000, 12, 2'b00);
        expect_out("after_rst", 32'hF000_0000);
        cycle();

        // Randomized traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid || in_x) begin
                bus.in_valid = 1'($urandom);
                bus.in_data  = $urandom;
                bus.in_sa    = LOG2W'($urandom_range(0, WIDTH - 1));
                bus.in_op    = 2'($urandom);
            end
            cycle();
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (PIPE + 3) cycle();
        check("random_drain_empty", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/shift_pipe.md
Name: shift_pipe

Overview:
- Parametrised, pipelined barrel shifter; the successor to the single-cycle 32-bit combinational shift mux.
- Adds generic data width, configurable pipeline depth, rotate modes and a valid/ready handshake with backpressure.
- Sits between the ALU operand latch and the writeback mux. It also serves as a standalone shift unit for the multi-cycle datapath.

Parameters:
- WIDTH, 32, data width; power of 2, 8..64; LOG2W = log2(WIDTH).
- PIPE, 2, register stages, 1..LOG2W; equals latency in cycles.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input operation present.
- in_ready  out  1  block accepts input this cycle.
- in_data  in  WIDTH  operand.
- in_sa  in  LOG2W  shift amount.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- out_data  out  WIDTH  result.

Behaviour:
- One clock; reset is asynchronous and active-high (clk, rst).
- Reset values:
  - All stage valid bits = 0, so out_valid = 0 and out_data = 0.
  - in_ready = 1 once rst deasserts. While rst is high, in_ready = 0.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Pipeline control:
  - Global-stall pipeline: advance = !out_valid | out_ready. All stage registers load only when advance = 1.
  - in_ready = advance (combinational from out_ready).
  - Bubbles are not squeezed: a stall freezes every stage, including empty ones.
  - Throughput is 1 op/cycle while out_ready = 1.
- Shift structure:
  - LOG2W mux levels. Level k shifts by 2^k when sa bit k = 1. Levels are processed MSB first (k = LOG2W-1 down to 0).
  - Each stage register holds data, remaining sa bits, op and valid.
  - A register boundary follows every ceil(LOG2W/PIPE) levels. The last register drives out_data, which is registered with no output combinational path.
  - Latency: a transfer accepted at edge N gives out_valid = 1 after edge N+PIPE-1, when no stall occurs. With PIPE = 1, the result is visible the cycle after acceptance.
  - Stalls add cycles one-for-one.
- Arithmetic:
  - SLL fills with 0.
  - SRL fills with 0.
  - SRA fills with in_data[WIDTH-1], which is captured at input and carried down the pipe as the fill bit.
  - ROR: bits shifted out at LSB re-enter at MSB.
- Boundaries:
  - sa = 0: out_data = in_data for all ops.
  - sa = WIDTH-1 is the maximum; no sa wrap-around beyond LOG2W bits exists.
- Stage valids:
  - A stage valid clears when advance = 1 and the preceding stage is empty (or, for the first stage, in_valid = 0).
  - out_valid holds with stable out_data until out_ready = 1.
- Reset mid-operation: all in-flight ops are discarded and no out_valid is produced for them after reset release.
- Simultaneous in-transfer and out-transfer in the same cycle is legal; occupancy is unchanged.

Optional Feature:
- Macro SHIFT_PIPE_CARRY_EN.
- When defined, adds output out_carry (1 bit), registered and aligned with out_data:
  - SLL: the last bit shifted out, in_data[WIDTH-sa].
  - SRL/SRA: in_data[sa-1].
  - ROR: out_data[WIDTH-1].
  - sa = 0: out_carry = 0 for all ops.
  - Reset value 0; held stable during stall.
- When undefined, the port and its pipeline bits are absent and the datapath is otherwise identical.

Test Plan:
- WIDTH=32, PIPE=2, out_ready=1: SRA of 0x80000000 by 4 -> out_data 0xF8000000, out_valid 2 edges after accept. SRL of the same -> 0x08000000.
- ROR of 0x12345678 by 8 -> 0x78123456. SLL of 0x0000FFFF by 16 -> 0xFFFF0000. sa=0 for each op -> data unchanged.
- Back-to-back ops with out_ready=1 -> one result per cycle, in order. Then hold out_ready=0 for 3 cycles -> in_ready=0, out_data stable; release -> no loss or duplication.
- Assert rst with 2 ops in flight -> out_valid=0 immediately; after release, no stale result appears and the next op's result is correct.
- Sweep PIPE=1..5, WIDTH=8/32/64, random data/sa/op against a reference model -> all match, latency = PIPE.
- With SHIFT_PIPE_CARRY_EN: SLL of 0x80000001 by 1 -> out_data 0x00000002, out_carry 1. SRL of 0x00000002 by 2 -> out_carry 1.
